// File: rtl/tdc_ones_sequencer.sv
// Time-multiplexed ones counter for a captured TDC thermometer code, LANES groups per cycle.
// Optional TDC_SEQ_BUBBLE_DETECT_EN adds oBubble, flagging codes that are not contiguous ones from the LSB.
module tdc_ones_sequencer #(
    parameter int N_GROUPS = 8,
    parameter int LANES    = 2
) (
    input  logic                                iClk,
    input  logic                                iRst_n,
    input  logic [6*N_GROUPS-1:0]               iData,
    input  logic                                iValid,
    output logic                                oReady,
    output logic [$clog2(6*N_GROUPS+1)-1:0]     oData,
    output logic                                oValid,
    input  logic                                iReady
`ifdef TDC_SEQ_BUBBLE_DETECT_EN
    ,
    output logic                                oBubble
`endif
);

    localparam int W        = 6 * N_GROUPS;
    localparam int S        = $clog2(W + 1);
    localparam int N_SLICES = N_GROUPS / LANES;
    localparam int IW       = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SLICES - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   capture_q;
    logic [S-1:0]   acc_q;
    logic [S-1:0]   acc_d;
    logic [IW-1:0]  idx_q;
    logic           ready_q;
    logic           valid_q;
    logic [S-1:0]   data_q;
    logic [S-1:0]   sliceSum;

    // One 6-input LUT worth of counting; exact for bubbled groups too.
    function automatic logic [2:0] popcount6(input logic [5:0] g);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            c = c + {2'b00, g[i]};
        end
        return c;
    endfunction

    always_comb begin
        sliceSum = '0;
        for (int l = 0; l < LANES; l++) begin
            sliceSum = sliceSum + S'(popcount6(capture_q[(int'(idx_q) * LANES + l) * 6 +: 6]));
        end
        acc_d = acc_q + sliceSum;
    end

`ifdef TDC_SEQ_BUBBLE_DETECT_EN
    logic bubble_q;
    logic bubble_d;

    // x & (x+1) is zero exactly when the ones form an unbroken run from bit 0.
    always_comb begin
        bubble_d = |(capture_q & (capture_q + W'(1)));
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            bubble_q <= 1'b0;
        end else if (state_q == COUNT && idx_q == LAST_IDX) begin
            bubble_q <= bubble_d;
        end else if (state_q == DONE && iReady) begin
            bubble_q <= 1'b0;
        end
    end

    assign oBubble = bubble_q;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            capture_q <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iValid) begin
                        capture_q <= iData;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= COUNT;
                    end
                end
                COUNT: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= acc_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_tdc_ones_sequencer.sv
// Scoreboard bench for tdc_ones_sequencer (N_GROUPS=8, LANES=2): stimulus pushes expected sums,
// a negedge monitor pops and compares on each accepted result.
module tb_tdc_ones_sequencer;

    localparam int W = 48;
    localparam int S = 6;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic [W-1:0]  iData;
    logic          iValid;
    logic          oReady;
    logic [S-1:0]  oData;
    logic          oValid;
    logic          iReady;
`ifdef TDC_SEQ_BUBBLE_DETECT_EN
    logic          oBubble;
`endif

    tdc_ones_sequencer #(.N_GROUPS(8), .LANES(2)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady)
`ifdef TDC_SEQ_BUBBLE_DETECT_EN
        ,
        .oBubble(oBubble)
`endif
    );

    always #5 iClk = ~iClk;

    int cycleCount = 0;
    always @(posedge iClk) cycleCount++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [S-1:0] sum;
        logic         bubble;
        int           capCycle;
        string        name;
    } exp_t;

    exp_t sbQ[$];

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    logic         prevValid  = 1'b0;
    logic         prevReady  = 1'b0;
    logic [S-1:0] prevData   = '0;
    logic         expectIdle = 1'b0;

    // Monitor: checks idle zeros, latency on the rising oValid, hold under back-pressure, and result on accept.
    always @(negedge iClk) begin
        exp_t e;
        if (expectIdle) begin
            checkOutput("idleAfterAccept.oValid", W'(oValid), W'(0));
            checkOutput("idleAfterAccept.oReady", W'(oReady), W'(1));
            expectIdle = 1'b0;
        end
        if (!oValid) begin
            checkOutput("zeroWhenInvalid.oData", W'(oData), W'(0));
`ifdef TDC_SEQ_BUBBLE_DETECT_EN
            checkOutput("zeroWhenInvalid.oBubble", W'(oBubble), W'(0));
`endif
        end else begin
            checkOutput("readyLowWhileValid", W'(oReady), W'(0));
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedOutput: got oValid=1 oData=%0d, expected no result", oData);
            end else begin
                if (!prevValid)
                    checkOutput({sbQ[0].name, ".latency"}, W'(cycleCount - sbQ[0].capCycle), W'(4));
                else if (!prevReady)
                    checkOutput({sbQ[0].name, ".hold"}, W'(oData), W'(prevData));
                if (iReady) begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, ".oData"}, W'(oData), W'(e.sum));
`ifdef TDC_SEQ_BUBBLE_DETECT_EN
                    checkOutput({e.name, ".oBubble"}, W'(oBubble), W'(e.bubble));
`endif
                    expectIdle = 1'b1;
                end
            end
        end
        prevValid = oValid;
        prevReady = iReady;
        prevData  = oData;
    end

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iClk);
            if (oReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL readyTimeout: got oReady=0 for 50 cycles, expected 1");
        end
    endtask

    // Capture one code; optionally pulse junk iValid during COUNT, which must be ignored.
    task automatic applyStimulus(input logic [W-1:0] code, input logic [S-1:0] sum, input logic bubble,
                                 input string name, input bit junk);
        bit   ok;
        exp_t e;
        waitReady(ok);
        if (!ok) return;
        iData  = code;
        iValid = 1'b1;
        e.sum = sum; e.bubble = bubble; e.capCycle = cycleCount + 1; e.name = name;
        sbQ.push_back(e);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iData  = ~code;
        if (junk) begin
            iValid = 1'b1;
            repeat (3) begin
                @(posedge iClk);
                #1;
            end
            iValid = 1'b0;
        end
    endtask

    task automatic holdTest();
        bit seen;
        applyStimulus(48'h0000_0000_0FFF, 6'd12, 1'b0, "hold", 1'b0);
        iReady = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            if (oValid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL holdValidTimeout: got oValid=0, expected 1 within 20 cycles");
        end
        @(posedge iClk);
        #1;
        iValid = 1'b1;
        iData  = 48'hFFFF_FFFF_FFFF;
        repeat (3) @(negedge iClk);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iReady = 1'b1;
    endtask

    task automatic resetTest();
        bit ok;
        waitReady(ok);
        if (!ok) return;
        iData  = 48'hFFFF_FFFF_FFFF;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        checkOutput("midReset.oValid", W'(oValid), W'(0));
        checkOutput("midReset.oData", W'(oData), W'(0));
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        @(negedge iClk);
        checkOutput("afterReset.oReady", W'(oReady), W'(1));
        repeat (8) @(negedge iClk);
        checkOutput("noResultAfterReset.oValid", W'(oValid), W'(0));
    endtask

    initial begin
        iRst_n = 1'b0;
        iData  = '0;
        iValid = 1'b0;
        iReady = 1'b1;
        #1;
        checkOutput("reset.oValid", W'(oValid), W'(0));
        checkOutput("reset.oData", W'(oData), W'(0));
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        @(negedge iClk);
        checkOutput("reset.oReady", W'(oReady), W'(1));

        applyStimulus(48'h0000_0000_0000, 6'd0,  1'b0, "zero",       1'b0);
        applyStimulus(48'h0000_FFFF_FFFF, 6'd32, 1'b0, "low32",      1'b1);
        applyStimulus(48'hFFFF_FFFF_FFFF, 6'd48, 1'b0, "allOnes",    1'b0);
        applyStimulus(48'h0000_0000_000B, 6'd3,  1'b1, "bubble0B",   1'b0);
        applyStimulus(48'h8000_0000_0001, 6'd2,  1'b1, "ends",       1'b0);
        applyStimulus(48'h0000_0000_0001, 6'd1,  1'b0, "single",     1'b0);
        applyStimulus(48'h5555_5555_5555, 6'd24, 1'b1, "alternate",  1'b1);
        applyStimulus(48'h0000_0000_003F, 6'd6,  1'b0, "oneGroup",   1'b0);
        applyStimulus(48'h7FFF_FFFF_FFFF, 6'd47, 1'b0, "allButTop",  1'b0);
        holdTest();
        resetTest();
        applyStimulus(48'h0000_00FF_FFFF, 6'd24, 1'b0, "postReset",  1'b0);

        for (int i = 0; i < 50 && sbQ.size() != 0; i++) @(negedge iClk);
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drainTimeout: got %0d pending results, expected 0", sbQ.size());
        end
        repeat (2) @(negedge iClk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_ones_sequencer.md
TDC_ONES_SEQUENCER -- requirements
Module: tdc_ones_sequencer

Interface
REQ-001 Parameter: N_GROUPS, default 8, number of 6-bit groups in the captured thermometer word (code width W = 6*N_GROUPS).
REQ-002 Parameter: LANES, default 2, number of shared 6-input LUT one-counters; N_GROUPS SHALL be an integer multiple of LANES.
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst_n  input  1  asynchronous, active-low reset.
REQ-005 iData  input  W  thermometer code sampled from the delay line.
REQ-006 iValid  input  1  iData is valid.
REQ-007 oReady  output  1  block accepts a new code this cycle.
REQ-008 oData  output  S  ones count of the captured code, S = clog2(W+1) (6 for defaults).
REQ-009 oValid  output  1  oData is valid.
REQ-010 iReady  input  1  consumer accepts oData.

Function
REQ-011 FSM states SHALL be IDLE, COUNT, DONE.
REQ-012 IDLE: oReady=1; on iValid=1, iData SHALL be captured into an internal register, accumulator cleared, slice index set to 0, next state COUNT.
REQ-013 COUNT: each cycle, LANES consecutive 6-bit groups (LSB-first, starting at group index*LANES) SHALL be popcounted (0..6 each) and added to the accumulator; index increments by 1.
REQ-014 COUNT SHALL last exactly N_GROUPS/LANES cycles; the edge adding the last slice SHALL enter DONE.
REQ-015 Latency: oValid SHALL rise N_GROUPS/LANES cycles after the capture edge (4 for defaults).
REQ-016 DONE: oValid=1, oData = accumulator; oData SHALL remain stable while iReady=0.
REQ-017 DONE with iReady=1 SHALL return to IDLE on that edge; oValid falls, oReady rises the next cycle (no back-to-back acceptance in DONE).
REQ-018 oReady SHALL be 0 in COUNT and DONE; iValid in those states SHALL be ignored and iData not sampled.
REQ-019 Accumulator width S SHALL not overflow; all-ones input yields exactly W.
REQ-020 oData SHALL be 0 whenever oValid=0.
REQ-021 Per-group popcount SHALL be exact for any 6-bit pattern, including non-thermometer (bubble) patterns.

Reset
REQ-022 iRst_n=0 SHALL immediately force state IDLE, oValid=0, oData=0, accumulator=0, index=0, capture register=0; oReady=1 after release.
REQ-023 Reset asserted during COUNT or DONE SHALL discard the in-flight result; no oValid pulse follows release.

Configuration
REQ-024 Macro TDC_SEQ_BUBBLE_DETECT_EN defined: output oBubble (1 bit) SHALL exist, valid with oValid, =1 iff the captured code is not of form 0...01...1 (ones contiguous from LSB), reset value 0, 0 when oValid=0.
REQ-025 Macro undefined: oBubble port and its logic SHALL be absent; all other behaviour identical.

Verification (N_GROUPS=8, LANES=2)
REQ-026 iData=48'h0 captured -> oValid high 4 cycles later, oData=0, oBubble=0.
REQ-027 iData=48'h0000_FFFF_FFFF -> oData=32, oBubble=0; iData=48'hFFFF_FFFF_FFFF -> oData=48.
REQ-028 iData=48'h0000_0000_000B -> oData=3, oBubble=1 (macro defined).
REQ-029 Result in DONE with iReady=0 for 3 cycles -> oValid/oData held; iReady=1 -> IDLE next edge, oReady=1; iValid pulses during COUNT/DONE ignored.
REQ-030 iRst_n pulled low during 2nd COUNT cycle -> outputs zero immediately; after release, oReady=1 and no oValid until a new capture.
